// File: rtl/terminal_port_arbiter_pkg.sv
// ============================================================================
// terminal_port_arbiter_pkg : shared text-terminal geometry, port indices, helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package terminal_port_arbiter_pkg;

  localparam int TERM_ADDR_W = 12;
  localparam int TERM_DATA_W = 8;
  localparam int TERM_COLS   = 80;
  localparam int TERM_ROWS   = 30;
  localparam int TERM_CELLS  = TERM_COLS * TERM_ROWS;

  localparam logic PORT_DBG = 1'b0;
  localparam logic PORT_CPU = 1'b1;

  // Outstanding read: one slot is enough because read latency is a fixed single clock.
  typedef struct packed {
    logic pend;
    logic owner;
  } rd_slot_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/terminal_port_arbiter_if.sv
// ============================================================================
// terminal_port_arbiter_if : requester-side and text-RAM-side signals of the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

interface terminal_port_arbiter_if
  import terminal_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = TERM_ADDR_W,
  parameter int DATA_W = TERM_DATA_W
) ();

  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_lock;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;

  logic [ADDR_W-1:0]   term_addr;
  logic                term_write;
  logic [DATA_W-1:0]   term_wdata;
  logic [DATA_W-1:0]   term_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_lock, term_rdata,
    input  req_ready, rsp_valid, rsp_rdata, term_addr, term_write, term_wdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_lock, term_rdata,
    output req_ready, rsp_valid, rsp_rdata, term_addr, term_write, term_wdata
  );

endinterface

`default_nettype wire

// File: rtl/terminal_port_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : combinational two-way round-robin grant with an optional forced owner
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
  import terminal_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       force_en,
  input  logic       force_port,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (force_en && valid[force_port]) begin
      grant = port_onehot(force_port);
    end else if (&valid) begin
      grant = port_onehot(~last_grant);
    end else if (valid[PORT_DBG]) begin
      grant = port_onehot(PORT_DBG);
    end else if (valid[PORT_CPU]) begin
      grant = port_onehot(PORT_CPU);
    end
  end

endmodule

`default_nettype wire

// File: rtl/terminal_port_arbiter.sv
// ============================================================================
// terminal_port_arbiter : shares the terminal text-RAM port between debugger and CPU
// Revision 1.0 -- optional grant locking enabled by defining TERM_ARB_LOCK_EN
// ============================================================================
`default_nettype none

module terminal_port_arbiter
  import terminal_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = TERM_ADDR_W,
  parameter int DATA_W   = TERM_DATA_W,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  terminal_port_arbiter_if.slave  bus
);

  logic [1:0] grant;
  logic       gsel;
  logic       xfer;
  logic       last_grant;
  logic       force_en;
  logic       force_port;
  rd_slot_t   rd_slot;

  rr_arbiter2 u_rr (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .force_en   (force_en),
    .force_port (force_port),
    .grant      (grant)
  );

  assign gsel = grant[PORT_CPU];
  assign xfer = |grant;

  assign bus.req_ready  = grant;
  assign bus.term_addr  = gsel ? bus.req_addr[ADDR_W +: ADDR_W]  : bus.req_addr[0 +: ADDR_W];
  assign bus.term_wdata = gsel ? bus.req_wdata[DATA_W +: DATA_W] : bus.req_wdata[0 +: DATA_W];
  assign bus.term_write = xfer & bus.req_write[gsel];

  // The RAM registers its output, so read data arrives exactly one clock after the address.
  assign bus.rsp_valid = rd_slot.pend ? port_onehot(rd_slot.owner) : 2'b00;
  assign bus.rsp_rdata = bus.term_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant    <= PORT_CPU;
      rd_slot.pend  <= 1'b0;
      rd_slot.owner <= PORT_DBG;
    end else begin
      rd_slot.pend  <= xfer & ~bus.req_write[gsel];
      rd_slot.owner <= gsel;
      if (xfer) begin
        last_grant <= gsel;
      end
    end
  end

`ifdef TERM_ARB_LOCK_EN
  logic       lock_active;
  logic       lock_port;
  logic [7:0] hold_cnt;
  logic [7:0] hold_next;

  assign force_en   = lock_active;
  assign force_port = lock_port;

  // A fresh lock (new owner or after a break) restarts the hold count at one.
  assign hold_next = (lock_active && (lock_port == gsel)) ? hold_cnt + 8'd1 : 8'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_port   <= PORT_DBG;
      hold_cnt    <= 8'd0;
    end else if (xfer && bus.req_lock[gsel] && (hold_next != 8'(MAX_HOLD))) begin
      lock_active <= 1'b1;
      lock_port   <= gsel;
      hold_cnt    <= hold_next;
    end else begin
      // Hitting MAX_HOLD lands here too; last_grant then hands the next contest over.
      lock_active <= 1'b0;
      hold_cnt    <= 8'd0;
    end
  end
`else
  logic       unused_lock;
  logic [7:0] unused_max_hold;

  assign force_en        = 1'b0;
  assign force_port      = PORT_DBG;
  assign unused_lock     = ^bus.req_lock;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

endmodule

`default_nettype wire

// File: tb/tb_terminal_port_arbiter.sv
// ============================================================================
// tb_terminal_port_arbiter : vector table, corner sequences and random run vs a reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_terminal_port_arbiter;
  import terminal_port_arbiter_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  terminal_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  terminal_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] init_byte(input int a);
    if (a == 'h010) return 8'h5A;
    if (a == 'h020) return 8'hC3;
    return DW'(a * 37 + 11);
  endfunction

  // Text RAM with registered read data, loaded on its first clock.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit ram_loaded = 1'b0;
  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_byte(i);
      ram_loaded <= 1'b1;
    end else begin
      if (bus.term_write) ram[bus.term_addr] <= bus.term_wdata;
      bus.term_rdata <= ram[bus.term_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected memory contents, arbitration history, pending response.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_last, m_lock, m_hold, m_rsp_port;
  logic [DW-1:0] m_rsp_data;
  int            wait_cnt [2];

  logic [1:0]    obs_ready, obs_rsp;
  logic          obs_write;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_rdata;

  function automatic int model_grant(input logic [1:0] v);
    if (v == 2'b00) return -1;
`ifdef TERM_ARB_LOCK_EN
    if (m_lock >= 0 && v[m_lock]) return m_lock;
`endif
    if (v == 2'b11) return 1 - m_last;
    return v[0] ? 0 : 1;
  endfunction

  task automatic model_reset();
    m_last = 1; m_lock = -1; m_hold = 0; m_rsp_port = -1;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
  endtask

  task automatic drive_idle();
    bus.req_valid = 2'b00; bus.req_write = 2'b00; bus.req_lock = 2'b00;
    bus.req_addr  = '0;    bus.req_wdata = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock: drive after the edge, compare on the falling edge, then advance the model.
  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [1:0] lk,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int            g;
    logic [1:0]    e_ready;
    logic          e_write;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge clock); #1;
    bus.req_valid = v;  bus.req_write = w;  bus.req_lock = lk;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    @(negedge clock);
    g       = model_grant(v);
    e_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    e_write = (g >= 0) ? w[g] : 1'b0;
    ea      = (g == 1) ? a1 : a0;
    ed      = (g == 1) ? d1 : d0;
    obs_ready = bus.req_ready;  obs_write = bus.term_write;
    obs_addr  = bus.term_addr;  obs_wdata = bus.term_wdata;
    obs_rsp   = bus.rsp_valid;  obs_rdata = bus.rsp_rdata;
    check("ready", 32'(obs_ready), 32'(e_ready));
    check("term_write", 32'(obs_write), 32'(e_write));
    check("term_addr", 32'(obs_addr), 32'(ea));
    check("term_wdata", 32'(obs_wdata), 32'(ed));
    check("rsp_valid", 32'(obs_rsp), (m_rsp_port < 0) ? 32'd0 : ((m_rsp_port == 0) ? 32'd1 : 32'd2));
    if (m_rsp_port >= 0) check("rsp_rdata", 32'(obs_rdata), 32'(m_rsp_data));
    for (int p = 0; p < 2; p++) begin
      if (v[p] && g != p) wait_cnt[p]++;
      else wait_cnt[p] = 0;
      if (v[p]) begin
        n_checks++;
        if (wait_cnt[p] > MH + 1) begin
          n_fail++;
          $display("FAIL wait_bound port%0d: waited %0d cycles, limit %0d", p, wait_cnt[p], MH + 1);
        end
      end
    end
    m_rsp_port = -1;
    if (g >= 0) begin
      m_last = g;
      if (w[g]) ref_mem[ea] = ed;
      else begin
        m_rsp_port = g;
        m_rsp_data = ref_mem[ea];
      end
`ifdef TERM_ARB_LOCK_EN
      if (lk[g]) begin
        m_hold = (m_lock == g) ? m_hold + 1 : 1;
        if (m_hold >= MH) begin m_hold = 0; m_lock = -1; end
        else m_lock = g;
      end else begin
        m_hold = 0; m_lock = -1;
      end
`endif
    end else begin
      m_lock = -1; m_hold = 0;
    end
  endtask

  typedef struct {
    logic [1:0]    v, w;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    e_ready;
    logic          e_write;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] w,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic [1:0] er, input logic ew,
                              input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd);
    vec_t t;
    t.v = v; t.w = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.e_ready = er; t.e_write = ew; t.e_addr = eaddr; t.e_wdata = ewd;
    return t;
  endfunction

  vec_t          tbl [10];
  logic [1:0]    lock_exp [6];
  logic [1:0]    rv, rw, rl;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_byte(i);
    drive_idle();
    model_reset();

    tbl[0] = mk(2'b01, 2'b11, 12'h005, 12'h100, 8'h41, 8'h99, 2'b01, 1'b1, 12'h005, 8'h41);
    tbl[1] = mk(2'b10, 2'b10, 12'h000, 12'h101, 8'h00, 8'h11, 2'b10, 1'b1, 12'h101, 8'h11);
    for (int k = 0; k < 6; k++) begin
      tbl[2+k] = mk(2'b11, 2'b11, 12'h200 + 12'(k), 12'h300 + 12'(k), 8'h60 + 8'(k), 8'h70 + 8'(k),
                    (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1,
                    (k % 2 == 0) ? 12'h200 + 12'(k) : 12'h300 + 12'(k),
                    (k % 2 == 0) ? 8'h60 + 8'(k) : 8'h70 + 8'(k));
    end
    tbl[8] = mk(2'b00, 2'b11, 12'h044, 12'h055, 8'hAA, 8'hBB, 2'b00, 1'b0, 12'h044, 8'hAA);
    tbl[9] = mk(2'b11, 2'b01, 12'h046, 12'h057, 8'hCC, 8'hDD, 2'b01, 1'b1, 12'h046, 8'hCC);

    // Reset state
    apply_reset();
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_ready_idle", 32'(bus.req_ready), 32'd0);
    check("reset_term_write", 32'(bus.term_write), 32'd0);

    // Vector table: single write, then alternating grants under contention
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].w, 2'b00, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      check($sformatf("tbl%0d_ready", i), 32'(obs_ready), 32'(tbl[i].e_ready));
      check($sformatf("tbl%0d_write", i), 32'(obs_write), 32'(tbl[i].e_write));
      check($sformatf("tbl%0d_addr", i), 32'(obs_addr), 32'(tbl[i].e_addr));
      check($sformatf("tbl%0d_wdata", i), 32'(obs_wdata), 32'(tbl[i].e_wdata));
    end

    // Contending reads: port1 served first, port0 stalled then served
    apply_reset();
    step(2'b01, 2'b01, 2'b00, 12'h0FF, 12'h000, 8'h12, 8'h00);
    step(2'b11, 2'b00, 2'b00, 12'h020, 12'h010, 8'h00, 8'h00);
    check("rd_contend_ready", 32'(obs_ready), 32'h2);
    step(2'b01, 2'b00, 2'b00, 12'h020, 12'h010, 8'h00, 8'h00);
    check("rd_p0_ready", 32'(obs_ready), 32'h1);
    check("rd_p1_rsp_valid", 32'(obs_rsp), 32'h2);
    check("rd_p1_rdata", 32'(obs_rdata), 32'h5A);
    step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00);
    check("rd_p0_rsp_valid", 32'(obs_rsp), 32'h1);
    check("rd_p0_rdata", 32'(obs_rdata), 32'hC3);

    // Reset between read acceptance and its response
    apply_reset();
    step(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 8'h00, 8'h00);
    check("midrd_ready", 32'(obs_ready), 32'h1);
    drive_idle();
    reset = 1'b1;
    model_reset();
    #1;
    check("midrd_rsp_in_reset", 32'(bus.rsp_valid), 32'h0);
    @(posedge clock); #1;
    check("midrd_rsp_after_edge", 32'(bus.rsp_valid), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    step(2'b11, 2'b11, 2'b00, 12'h3F0, 12'h3F1, 8'h01, 8'h02);
    check("midrd_rsp_released", 32'(obs_rsp), 32'h0);
    check("midrd_first_contest", 32'(obs_ready), 32'h1);

    // Port1 holding lock against a steadily requesting port0
`ifdef TERM_ARB_LOCK_EN
    lock_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
    lock_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step((i == 0) ? 2'b10 : 2'b11, 2'b11, 2'b10, 12'h400 + 12'(i), 12'h410 + 12'(i),
           8'h80 + 8'(i), 8'h90 + 8'(i));
      check($sformatf("lock_seq%0d", i), 32'(obs_ready), 32'(lock_exp[i]));
    end

    // Random traffic against the reference model
    apply_reset();
    rv = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(rv[p] && !obs_ready[p] && $urandom_range(0, 9) < 8))
          rv[p] = ($urandom_range(0, 9) < 6);
      end
      rw  = 2'($urandom);
      rl  = 2'($urandom);
      ra0 = AW'($urandom_range(0, 31));
      ra1 = AW'($urandom_range(0, 31));
      rd0 = DW'($urandom);
      rd1 = DW'($urandom);
      step(rv, rw, rl, ra0, ra1, rd0, rd1);
    end
    step(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
